// File: rtl/cla_pipe_addsub.sv
// ---------------------------------------------------------------------------
// cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
// Each pipeline stage resolves GROUPS_PER_STAGE groups and passes its
// carry-out, the partial sum and the still-unprocessed operand slices on to
// the next stage.  The last stage is the output register.  Every stage has
// a valid bit and advances when it is empty or the stage after it advances,
// so bubbles collapse and back-pressure fills the pipe before in_ready drops.
//
// Optional feature: define CLA_PIPE_SAT_EN to add the `sat` input, which
// clamps an overflowing result to signed max/min according to X's sign.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (transfer on in_valid & in_ready)
//   X, Y, Cin, sub      operands, carry-in (add only), 1 = X - Y
//   sat                 (CLA_PIPE_SAT_EN only) saturate on signed overflow
//   out_valid/out_ready result handshake (consume on out_valid & out_ready)
//   S, Cout, V, Z, N    result, raw carry out, signed overflow, zero, negative
// ---------------------------------------------------------------------------
module cla_pipe_addsub #(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int unsigned SW     = 4 * GROUPS_PER_STAGE;
    localparam int unsigned STAGES = WIDTH / SW;
    localparam int unsigned L      = STAGES - 1;

    if (GROUPS_PER_STAGE == 0 || WIDTH == 0 || (WIDTH % SW) != 0) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of 4*GROUPS_PER_STAGE");
    end

    // 4-bit lookahead group: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci);
        logic [3:0] p, g;
        logic [4:0] c;
        p    = a | b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], a ^ b ^ c[3:0]};
    endfunction

    // Output (last-stage) registers
    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, v_q, z_q, n_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operand bits entering stage k: [WIDTH-1 : k*SW]
        localparam int unsigned RW = WIDTH - k * SW;

        logic              v_in, c_in, adv;
        logic [RW-1:0]     x_in, y_in;
        logic [SW-1:0]     sum_d;
        logic              c_d;
        logic [k*SW+SW-1:0] s_d;
`ifdef CLA_PIPE_SAT_EN
        logic              sat_in;
`endif

        if (k == 0) begin : g_src
            // Subtract folds into add: invert Y and force carry-in to 1
            assign v_in  = in_valid;
            assign x_in  = X;
            assign y_in  = sub ? ~Y : Y;
            assign c_in  = sub | Cin;
            assign s_d   = sum_d;
`ifdef CLA_PIPE_SAT_EN
            assign sat_in = sat;
`endif
        end else begin : g_nxt
            assign v_in  = g_st[k-1].g_reg.v_q;
            assign x_in  = g_st[k-1].g_reg.xr_q;
            assign y_in  = g_st[k-1].g_reg.yr_q;
            assign c_in  = g_st[k-1].g_reg.c_q;
            assign s_d   = {sum_d, g_st[k-1].g_reg.s_q};
`ifdef CLA_PIPE_SAT_EN
            assign sat_in = g_st[k-1].g_reg.sat_q;
`endif
        end

        always_comb begin
            logic [4:0] r;
            logic       cc;
            sum_d = '0;
            r     = '0;
            cc    = c_in;
            for (int unsigned g = 0; g < GROUPS_PER_STAGE; g++) begin
                r = cla4(x_in[g*4 +: 4], y_in[g*4 +: 4], cc);
                sum_d[g*4 +: 4] = r[3:0];
                cc = r[4];
            end
            c_d = cc;
        end

        if (k < STAGES - 1) begin : g_reg
            logic                v_q, c_q;
            logic [RW-SW-1:0]    xr_q, yr_q;
            logic [k*SW+SW-1:0]  s_q;
`ifdef CLA_PIPE_SAT_EN
            logic                sat_q;
`endif
            assign adv = ~v_q | g_st[k+1].adv;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q  <= 1'b0;
                    c_q  <= 1'b0;
                    xr_q <= '0;
                    yr_q <= '0;
                    s_q  <= '0;
`ifdef CLA_PIPE_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (adv) begin
                    v_q <= v_in;
                    // data only moves with a valid token, so bubbles leave it untouched
                    if (v_in) begin
                        c_q  <= c_d;
                        xr_q <= x_in[RW-1:SW];
                        yr_q <= y_in[RW-1:SW];
                        s_q  <= s_d;
`ifdef CLA_PIPE_SAT_EN
                        sat_q <= sat_in;
`endif
                    end
                end
            end
        end else begin : g_last
            assign adv = ~out_valid_q | out_ready;
        end
    end

    assign in_ready = ~rst & g_st[0].adv;

    logic [WIDTH-1:0] res_d;
    logic             cout_d, ovf_d, xm, ym;

    always_comb begin
        xm     = g_st[L].x_in[SW-1];
        ym     = g_st[L].y_in[SW-1];
        res_d  = g_st[L].s_d;
        cout_d = g_st[L].c_d;
        // carry into the MSB is recovered as sum ^ x ^ y at that bit
        ovf_d  = res_d[WIDTH-1] ^ xm ^ ym ^ cout_d;
`ifdef CLA_PIPE_SAT_EN
        if (g_st[L].sat_in && ovf_d) begin
            res_d = xm ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
        end else if (g_st[L].adv) begin
            out_valid_q <= g_st[L].v_in;
            if (g_st[L].v_in) begin
                s_q    <= res_d;
                cout_q <= cout_d;
                v_q    <= ovf_d;
                z_q    <= ~|res_d;
                n_q    <= res_d[WIDTH-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign Z         = z_q;
    assign N         = n_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and randomized bench for cla_pipe_addsub (WIDTH=32, 2 groups/stage).
module tb_cla_pipe_addsub;

    localparam int unsigned STAGES = 4;
    localparam int          NRAND  = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] X, Y;
    logic        Cin, sub, sat_tb;
    logic        out_valid, out_ready;
    logic [31:0] S;
    logic        Cout, V, Z, N;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_pipe_addsub #(
        .WIDTH            (32),
        .GROUPS_PER_STAGE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Cin       (Cin),
        .sub       (sub),
`ifdef CLA_PIPE_SAT_EN
        .sat       (sat_tb),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .V         (V),
        .Z         (Z),
        .N         (N)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {S, Cout, V, Z, N}
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s, input logic st);
        logic [31:0] yy, r;
        logic [32:0] t;
        logic        v;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {32'd0, (s | c)};
        v  = (x[31] == yy[31]) && (t[31] != x[31]);
        r  = t[31:0];
`ifdef CLA_PIPE_SAT_EN
        if (st && v) r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (st && 1'b0) r = '0;
`endif
        return {r, t[32], v, (r == 32'd0), r[31]};
    endfunction

    // Inputs change at posedge+1, outputs are read at posedge+2.
    task automatic op1(input logic [31:0] x, input logic [31:0] y, input logic c,
                       input logic s, input logic st, output int lat);
        int w;
        @(posedge clk); #1;
        X = x; Y = y; Cin = c; sub = s; sat_tb = st; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #2; w++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #2; lat++; end
    endtask

    task automatic dir(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic c, input logic s, input logic st, input logic [35:0] exp);
        int lat;
        op1(x, y, c, s, st, lat);
        check_eq({tag, "_lat"}, 64'(lat), 64'(STAGES - 1));
        check_eq(tag, 64'({S, Cout, V, Z, N}), 64'(exp));
    endtask

    initial begin
        int acc, cyc, got, nr, pushed, seen;
        logic do_acc, pend;
        logic [35:0] q[$];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        X = '0; Y = '0; Cin = 1'b0; sub = 1'b0; sat_tb = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_inready_low", 64'(in_ready), 64'(0));
        check_eq("rst_outvalid", 64'(out_valid), 64'(0));
        check_eq("rst_outputs", 64'({S, Cout, V, Z, N}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("rst_inready_after", 64'(in_ready), 64'(1));

        // ---------------- directed arithmetic ----------------
        //                                             S              Cout  V     Z     N
        dir("add_wrap",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
        dir("add_ovf",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
        dir("sub_bor_c1", 32'h5,         32'h7, 1'b1, 1'b1, 1'b0, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1});
        dir("sub_bor_c0", 32'h5,         32'h7, 1'b0, 1'b1, 1'b0, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1});
        dir("sub_nobor",  32'h7,         32'h5, 1'b0, 1'b1, 1'b0, {32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0});
        dir("add_chain",  32'h00FF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, {32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0});
        dir("add_cin",    32'h0000_000F, 32'h1, 1'b1, 1'b0, 1'b0, {32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b0});
        dir("sub_ovf",    32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
        dir("sub_zero",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
`ifdef CLA_PIPE_SAT_EN
        dir("sat_pos",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0});
        dir("sat_neg",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, {32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1});
        dir("sat_noovf",  32'h1, 32'h2, 1'b0, 1'b0, 1'b1, {32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0});
`endif

        // ---------------- back-pressure ----------------
        @(posedge clk); #1;
        out_ready = 1'b0; sat_tb = 1'b0; acc = 0; cyc = 0;
        while (acc < 8 && cyc < 20) begin
            X = 32'(acc); Y = 32'(acc); Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            #1;
            if (!in_ready) break;
            @(posedge clk); #1;
            acc++; cyc++;
        end
        check_eq("bp_accepts", 64'(acc), 64'(STAGES));
        check_eq("bp_outvalid", 64'(out_valid), 64'(1));
        repeat (3) begin @(posedge clk); #2; end
        check_eq("bp_hold_ready", 64'(in_ready), 64'(0));
        check_eq("bp_hold_S", 64'(S), 64'(0));

        @(posedge clk); #1;
        out_ready = 1'b1; nr = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 30) begin
            if (acc < 8) begin X = 32'(acc); Y = 32'(acc); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (in_valid && !in_ready) nr++;
            do_acc = in_valid && in_ready;
            if (out_valid) begin
                check_eq("bp_seq", 64'(S), 64'(2 * got));
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (do_acc) acc++;
        end
        in_valid = 1'b0;
        check_eq("bp_count", 64'(got), 64'(8));
        check_eq("bp_cycles", 64'(cyc), 64'(8));
        check_eq("bp_stall_ready", 64'(nr), 64'(0));

        // ---------------- reset mid-stream ----------------
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            X = 32'(100 + i); Y = 32'h1; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("mrst_outvalid", 64'(out_valid), 64'(0));
        check_eq("mrst_outputs", 64'({S, Cout, V, Z, N}), 64'(0));
        check_eq("mrst_inready", 64'(in_ready), 64'(1));
        seen = 0;
        repeat (8) begin @(posedge clk); #2; if (out_valid) seen++; end
        check_eq("mrst_no_ghost", 64'(seen), 64'(0));
        dir("mrst_add", 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, {32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0});

        // ---------------- random regression ----------------
        pushed = 0; cyc = 0; pend = 1'b0;
        while ((pushed < NRAND || q.size() != 0) && cyc < 60000) begin
            @(posedge clk); #1;
            if (!pend && pushed < NRAND && $urandom_range(0, 3) != 0) begin
                X = $urandom; Y = $urandom;
                Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                sat_tb = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(model(X, Y, Cin, sub, sat_tb));
                pushed++;
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check_eq("rand_extra", 64'(out_valid), 64'(0));
                else check_eq("rand", 64'({S, Cout, V, Z, N}), 64'(q.pop_front()));
            end
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("rand_pushed", 64'(pushed), 64'(NRAND));
        check_eq("rand_drained", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
